// File: rtl/acc_topk_sorter_pkg.sv
// acc_topk_pkg: shared types and the ordering rule for the top-K accumulate/sort block.
package acc_topk_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_IDX_W  = 32;

   // List entry at the default widths; parameterised modules declare the same
   // {valid, value, index} layout at their own widths.
   typedef struct packed {
      logic                         valid;
      logic signed [DEF_DATA_W-1:0] value;
      logic [DEF_IDX_W-1:0]         index;
   } topk_entry_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCUM  = 2'd1,
      ST_INSERT = 2'd2,
      ST_DUMP   = 2'd3
   } topk_state_e;

   // True when a is strictly better than b: smaller in ascending mode, larger otherwise.
   function automatic logic better(input logic signed [63:0] a,
                                   input logic signed [63:0] b,
                                   input logic               asce);
      logic res;
      if (asce) begin
         res = (a < b);
      end else begin
         res = (a > b);
      end
      return res;
   endfunction

endpackage

// File: rtl/acc_topk_sorter_insert_row.sv
// topk_insert_row: combinational compare-and-shift network. Given a sorted list
// and one new item, it produces the list with the item inserted after every
// entry that is better or equal (older entries win ties). If every slot is kept
// the item is dropped; otherwise the last slot falls off the end.
module topk_insert_row
   import acc_topk_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int IDX_W  = 32,
   parameter int K      = 8
) (
   input  logic [K*(1+DATA_W+IDX_W)-1:0] list_i,
   input  logic signed [DATA_W-1:0]      new_value,
   input  logic [IDX_W-1:0]              new_index,
   input  logic                          asce,
   output logic [K*(1+DATA_W+IDX_W)-1:0] list_o
);

   typedef struct packed {
      logic                     valid;
      logic signed [DATA_W-1:0] value;
      logic [IDX_W-1:0]         index;
   } entry_t;

   entry_t [K-1:0] cur_s;
   entry_t [K-1:0] nxt_s;
   entry_t         new_s;
   logic   [K-1:0] keep_s;

   assign cur_s  = list_i;
   assign new_s  = {1'b1, new_value, new_index};
   assign list_o = nxt_s;

   // A slot stays put when it holds an entry at least as good as the new item.
   always_comb begin
      keep_s = '0;
      for (int i = 0; i < K; i++) begin
         keep_s[i] = cur_s[i].valid &&
                     !better(64'(new_value), 64'($signed(cur_s[i].value)), asce);
      end
   end

   // The first non-kept slot takes the new item; later slots take their predecessor.
   always_comb begin
      nxt_s = cur_s;
      if (keep_s[0]) begin
         nxt_s[0] = cur_s[0];
      end else begin
         nxt_s[0] = new_s;
      end
      for (int i = 1; i < K; i++) begin
         if (keep_s[i]) begin
            nxt_s[i] = cur_s[i];
         end else if (keep_s[i-1]) begin
            nxt_s[i] = new_s;
         end else begin
            nxt_s[i] = cur_s[i-1];
         end
      end
   end

endmodule

// File: rtl/acc_topk_sorter.sv
// acc_topk_sorter: sums NUM_CH signed lanes per beat, accumulates a programmable
// number of beats per instance, saturates and optionally clamps negatives, then
// keeps the best K (value, index) pairs in a sorted register list that can be
// streamed out non-destructively.
module acc_topk_sorter
   import acc_topk_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int NUM_CH = 4,
   parameter int K      = 8,
   parameter int IDX_W  = 32,
   parameter int LEN_W  = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [LEN_W-1:0]           cfg_acc_len,
   input  logic                       cfg_asce,
   input  logic                       cfg_relu_en,
   input  logic                       clear,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [NUM_CH*DATA_W-1:0]   in_data,
   input  logic [IDX_W-1:0]           in_index,
   input  logic                       dump_start,
   output logic                       dump_valid,
   input  logic                       dump_ready,
   output logic [DATA_W-1:0]          dump_data,
   output logic [IDX_W-1:0]           dump_index,
   output logic                       dump_last,
   output logic [$clog2(K+1)-1:0]     count,
   output logic                       busy
);

   localparam int ACC_W = DATA_W + LEN_W + $clog2(NUM_CH);
   localparam int CNT_W = $clog2(K+1);
   localparam int PTR_W = $clog2(K);
   localparam logic [CNT_W-1:0] K_CNT = CNT_W'(K);
   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   typedef struct packed {
      logic                     valid;
      logic signed [DATA_W-1:0] value;
      logic [IDX_W-1:0]         index;
   } entry_t;

   topk_state_e              state_q, state_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic [LEN_W-1:0]         beat_cnt_q, beat_cnt_d;
   logic [LEN_W-1:0]         len_q, len_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic                     asce_q, asce_d;
   logic                     relu_q, relu_d;
   entry_t [K-1:0]           list_q, list_d;
   logic [CNT_W-1:0]         count_q, count_d;
   logic [PTR_W-1:0]         dump_ptr_q, dump_ptr_d;

   logic signed [ACC_W-1:0]  lane_sum_s;
   logic [LEN_W-1:0]         len_eff_s;
   logic signed [DATA_W-1:0] sat_s;
   logic signed [DATA_W-1:0] ins_value_s;
   entry_t [K-1:0]           row_list_s;
   logic                     last_s;

   assign len_eff_s = (cfg_acc_len == '0) ? LEN_W'(1) : cfg_acc_len;
   assign last_s    = (CNT_W'(dump_ptr_q) == (count_q - CNT_W'(1)));
   assign count     = count_q;

   // Sign-extend every lane and add them into one beat total.
   always_comb begin
      lane_sum_s = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         lane_sum_s = lane_sum_s + ACC_W'($signed(in_data[c*DATA_W +: DATA_W]));
      end
   end

   // Saturate the finished accumulation to DATA_W, then apply the latched ReLU.
   always_comb begin
      if (acc_q > SAT_MAX) begin
         sat_s = {1'b0, {(DATA_W-1){1'b1}}};
      end else if (acc_q < SAT_MIN) begin
         sat_s = {1'b1, {(DATA_W-1){1'b0}}};
      end else begin
         sat_s = acc_q[DATA_W-1:0];
      end
      if (relu_q && sat_s[DATA_W-1]) begin
         ins_value_s = '0;
      end else begin
         ins_value_s = sat_s;
      end
   end

   topk_insert_row #(
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W),
      .K      (K)
   ) u_insert_row (
      .list_i    (list_q),
      .new_value (ins_value_s),
      .new_index (idx_q),
      .asce      (asce_q),
      .list_o    (row_list_s)
   );

   // Next-state logic: clear wins over everything; a beat wins over dump_start in IDLE.
   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      beat_cnt_d = beat_cnt_q;
      len_d      = len_q;
      idx_d      = idx_q;
      asce_d     = asce_q;
      relu_d     = relu_q;
      list_d     = list_q;
      count_d    = count_q;
      dump_ptr_d = dump_ptr_q;
      if (clear) begin
         state_d    = ST_IDLE;
         list_d     = '0;
         count_d    = '0;
         dump_ptr_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  acc_d      = lane_sum_s;
                  beat_cnt_d = LEN_W'(1);
                  len_d      = len_eff_s;
                  idx_d      = in_index;
                  asce_d     = cfg_asce;
                  relu_d     = cfg_relu_en;
                  if (len_eff_s == LEN_W'(1)) begin
                     state_d = ST_INSERT;
                  end else begin
                     state_d = ST_ACCUM;
                  end
               end else if (dump_start && (count_q != '0)) begin
                  state_d    = ST_DUMP;
                  dump_ptr_d = '0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_ACCUM: begin
               if (in_valid) begin
                  acc_d      = acc_q + lane_sum_s;
                  beat_cnt_d = beat_cnt_q + LEN_W'(1);
                  if ((beat_cnt_q + LEN_W'(1)) == len_q) begin
                     state_d = ST_INSERT;
                  end else begin
                     state_d = ST_ACCUM;
                  end
               end else begin
                  state_d = ST_ACCUM;
               end
            end
            ST_INSERT: begin
               list_d = row_list_s;
               if (count_q == K_CNT) begin
                  count_d = K_CNT;
               end else begin
                  count_d = count_q + CNT_W'(1);
               end
               state_d = ST_IDLE;
            end
            ST_DUMP: begin
               if (dump_ready) begin
                  if (last_s) begin
                     state_d    = ST_IDLE;
                     dump_ptr_d = '0;
                  end else begin
                     dump_ptr_d = dump_ptr_q + PTR_W'(1);
                  end
               end else begin
                  state_d = ST_DUMP;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         acc_q      <= '0;
         beat_cnt_q <= '0;
         len_q      <= '0;
         idx_q      <= '0;
         asce_q     <= 1'b0;
         relu_q     <= 1'b0;
         list_q     <= '0;
         count_q    <= '0;
         dump_ptr_q <= '0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         beat_cnt_q <= beat_cnt_d;
         len_q      <= len_d;
         idx_q      <= idx_d;
         asce_q     <= asce_d;
         relu_q     <= relu_d;
         list_q     <= list_d;
         count_q    <= count_d;
         dump_ptr_q <= dump_ptr_d;
      end
   end

   // Handshake and readout outputs decoded from registered state; data is zero outside DUMP.
   always_comb begin
      in_ready   = (state_q == ST_IDLE) || (state_q == ST_ACCUM);
      busy       = (state_q != ST_IDLE);
      dump_valid = (state_q == ST_DUMP);
      if (state_q == ST_DUMP) begin
         dump_data  = list_q[dump_ptr_q].value;
         dump_index = list_q[dump_ptr_q].index;
         dump_last  = last_s;
      end else begin
         dump_data  = '0;
         dump_index = '0;
         dump_last  = 1'b0;
      end
   end

endmodule

// File: tb/tb_acc_topk_sorter.sv
// tb_acc_topk_sorter: table-driven directed cases plus randomized instances
// checked against a queue-based reference list (K=4, NUM_CH=4, DATA_W=32).
module tb_acc_topk_sorter;

   localparam int DATA_W = 32;
   localparam int NUM_CH = 4;
   localparam int K      = 4;
   localparam int IDX_W  = 32;
   localparam int LEN_W  = 16;
   localparam int CNT_W  = $clog2(K+1);
   localparam longint VMAX = 64'sd2147483647;
   localparam longint VMIN = -VMAX - 64'sd1;

   logic                     clk;
   logic                     rst;
   logic [LEN_W-1:0]         cfg_acc_len;
   logic                     cfg_asce;
   logic                     cfg_relu_en;
   logic                     clear;
   logic                     in_valid;
   logic                     in_ready;
   logic [NUM_CH*DATA_W-1:0] in_data;
   logic [IDX_W-1:0]         in_index;
   logic                     dump_start;
   logic                     dump_valid;
   logic                     dump_ready;
   logic [DATA_W-1:0]        dump_data;
   logic [IDX_W-1:0]         dump_index;
   logic                     dump_last;
   logic [CNT_W-1:0]         count;
   logic                     busy;

   typedef struct { longint v; longint idx; } ent_t;
   typedef struct { logic [127:0] data; int idx; int exp_count; } vec_t;

   ent_t         model[$];
   ent_t         exp_q[$];
   logic [127:0] beats_r [16];
   vec_t         tbl [5];
   int           cmp_cnt = 0;
   int           err_cnt = 0;

   acc_topk_sorter #(
      .DATA_W(DATA_W), .NUM_CH(NUM_CH), .K(K), .IDX_W(IDX_W), .LEN_W(LEN_W)
   ) dut (
      .clk(clk), .rst(rst), .cfg_acc_len(cfg_acc_len), .cfg_asce(cfg_asce),
      .cfg_relu_en(cfg_relu_en), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_index(in_index), .dump_start(dump_start),
      .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
      .dump_index(dump_index), .dump_last(dump_last), .count(count), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1);
   end

   task automatic check(input string name, input longint act, input longint exp);
      cmp_cnt++;
      if (act != exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   function automatic logic [127:0] mk(input int a, input int b, input int c, input int d);
      return {d, c, b, a};
   endfunction

   function automatic longint lane_sum(input logic [127:0] d);
      longint s = 0;
      for (int c = 0; c < 4; c++) s += longint'($signed(d[c*32 +: 32]));
      return s;
   endfunction

   function automatic longint model_value(input longint acc, input bit relu);
      longint v = acc;
      if (v > VMAX) v = VMAX;
      else if (v < VMIN) v = VMIN;
      if (relu && v < 0) v = 0;
      return v;
   endfunction

   // Reference list: new item goes in front of the first strictly worse entry.
   function automatic void model_insert(input longint v, input longint idx, input bit asce);
      int   pos = model.size();
      ent_t e;
      e.v = v;
      e.idx = idx;
      for (int i = 0; i < model.size(); i++) begin
         if (asce ? (v < model[i].v) : (v > model[i].v)) begin
            pos = i;
            break;
         end
      end
      if (pos >= K) return;
      model.insert(pos, e);
      if (model.size() > K) void'(model.pop_back());
   endfunction

   function automatic int rlane();
      if ($urandom_range(0, 7) == 0) return int'($urandom);
      return int'($urandom_range(0, 40)) - 20;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_count"}, count, 0);
      check({tag, "_in_ready"}, in_ready, 1);
      check({tag, "_dump_valid"}, dump_valid, 0);
      check({tag, "_dump_last"}, dump_last, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_dump_data"}, dump_data, 0);
      check({tag, "_dump_index"}, dump_index, 0);
   endtask

   task automatic clear_pulse();
      clear = 1'b1;
      step();
      clear = 1'b0;
      model.delete();
      check("clear_count", count, 0);
   endtask

   // Sends one instance from beats_r; optionally disturbs cfg after the first beat.
   task automatic send_instance(input int len_cfg, input int idx, input bit wiggle);
      int     n;
      bit     a;
      bit     r;
      longint acc;
      n   = (len_cfg == 0) ? 1 : len_cfg;
      a   = cfg_asce;
      r   = cfg_relu_en;
      acc = 0;
      cfg_acc_len = LEN_W'(len_cfg);
      for (int b = 0; b < n; b++) begin
         check("beat_ready", in_ready, 1);
         in_valid = 1'b1;
         in_data  = beats_r[b];
         in_index = (b == 0) ? IDX_W'(idx) : $urandom;
         acc += lane_sum(beats_r[b]);
         step();
         if (wiggle && b == 0) begin
            cfg_acc_len = LEN_W'($urandom_range(1, 3));
            cfg_relu_en = ~r;
            cfg_asce    = ~a;
         end
      end
      in_valid = 1'b0;
      check("insert_ready", in_ready, 0);
      check("insert_busy", busy, 1);
      step();
      check("post_ready", in_ready, 1);
      check("post_busy", busy, 0);
      cfg_acc_len = LEN_W'(len_cfg);
      cfg_relu_en = r;
      cfg_asce    = a;
      model_insert(model_value(acc, r), longint'(idx), a);
      check("count", count, model.size());
   endtask

   // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready.
   task automatic dump_and_check(input int mode);
      int   n;
      int   got;
      int   cyc;
      logic rdy;
      n   = exp_q.size();
      got = 0;
      cyc = 0;
      dump_start = 1'b1;
      step();
      dump_start = 1'b0;
      while (got < n && cyc < 300) begin
         case (mode)
            1:       rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            2:       rdy = 1'($urandom_range(0, 1));
            default: rdy = 1'b1;
         endcase
         dump_ready = rdy;
         check("dump_valid", dump_valid, 1);
         check("dump_data", longint'($signed(dump_data)), exp_q[got].v);
         check("dump_index", longint'(dump_index), exp_q[got].idx);
         check("dump_last", dump_last, (got == n - 1) ? 1 : 0);
         step();
         if (rdy) got++;
         cyc++;
      end
      dump_ready = 1'b0;
      check("dump_done", got, n);
      check("dump_end_valid", dump_valid, 0);
      check("dump_end_busy", busy, 0);
   endtask

   initial begin
      int len;
      int n;
      rst = 1'b0; cfg_acc_len = '0; cfg_asce = 1'b0; cfg_relu_en = 1'b0;
      clear = 1'b0; in_valid = 1'b0; in_data = '0; in_index = '0;
      dump_start = 1'b0; dump_ready = 1'b0;

      tbl[0] = '{mk(2, 1, 1, 1),    0, 1};
      tbl[1] = '{mk(12, -1, -1, -1), 1, 2};
      tbl[2] = '{mk(-3, 5, 0, 0),   2, 3};
      tbl[3] = '{mk(7, 0, 0, 0),    3, 4};
      tbl[4] = '{mk(3, 3, 3, 0),    4, 4};

      step();
      step();
      check_reset("reset");
      rst = 1'b1;
      step();

      // Descending, len=1: sums 5, 9, 2, 7, 9.
      for (int i = 0; i < 5; i++) begin
         beats_r[0] = tbl[i].data;
         send_instance(1, tbl[i].idx, 1'b0);
         check("tbl_count", count, tbl[i].exp_count);
      end
      exp_q.delete();
      exp_q.push_back('{9, 1});
      exp_q.push_back('{9, 4});
      exp_q.push_back('{7, 3});
      exp_q.push_back('{5, 0});
      dump_and_check(0);

      // dump_start on an empty list is ignored.
      clear_pulse();
      dump_start = 1'b1;
      step();
      dump_start = 1'b0;
      check("empty_dump_valid", dump_valid, 0);
      check("empty_dump_busy", busy, 0);

      // Ascending, ReLU on, len=3: -12 (idx 7) and 4 (idx 8).
      cfg_asce = 1'b1;
      cfg_relu_en = 1'b1;
      for (int b = 0; b < 3; b++) beats_r[b] = mk(-1, -1, -1, -1);
      send_instance(3, 7, 1'b0);
      beats_r[0] = mk(5, -3, 0, 0);
      beats_r[1] = mk(1, 0, 0, 0);
      beats_r[2] = mk(0, 0, 0, 1);
      send_instance(3, 8, 1'b0);
      check("asc_count", count, 2);
      exp_q.delete();
      exp_q.push_back('{0, 7});
      exp_q.push_back('{4, 8});
      dump_and_check(0);

      // Saturation both ways, len=0 treated as 1, then backpressured dumps.
      clear_pulse();
      cfg_asce = 1'b0;
      cfg_relu_en = 1'b0;
      for (int b = 0; b < 4; b++) beats_r[b] = mk(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF);
      send_instance(4, 20, 1'b0);
      for (int b = 0; b < 4; b++) beats_r[b] = mk(32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000);
      send_instance(4, 21, 1'b0);
      beats_r[0] = mk(4, 3, 2, 1);
      send_instance(0, 22, 1'b0);
      exp_q.delete();
      exp_q.push_back('{VMAX, 20});
      exp_q.push_back('{10, 22});
      exp_q.push_back('{VMIN, 21});
      dump_and_check(1);
      dump_and_check(0);

      // clear together with the last beat of an instance.
      clear_pulse();
      cfg_acc_len = LEN_W'(2);
      in_valid = 1'b1; in_data = mk(1, 1, 1, 1); in_index = 30;
      step();
      in_data = mk(2, 2, 2, 2); clear = 1'b1;
      step();
      in_valid = 1'b0; clear = 1'b0;
      check("clr_beat_count", count, 0);
      check("clr_beat_ready", in_ready, 1);
      check("clr_beat_busy", busy, 0);
      step();
      check("clr_beat_late_count", count, 0);

      // clear together with dump_start.
      beats_r[0] = mk(1, 0, 0, 0);
      send_instance(1, 31, 1'b0);
      dump_start = 1'b1; clear = 1'b1;
      step();
      dump_start = 1'b0; clear = 1'b0;
      model.delete();
      check("clr_dump_valid", dump_valid, 0);
      check("clr_dump_count", count, 0);
      check("clr_dump_ready", in_ready, 1);

      // clear in the middle of a dump.
      beats_r[0] = mk(1, 0, 0, 0);
      send_instance(1, 32, 1'b0);
      beats_r[0] = mk(2, 0, 0, 0);
      send_instance(1, 33, 1'b0);
      dump_start = 1'b1;
      step();
      dump_start = 1'b0;
      check("mid_dump_valid", dump_valid, 1);
      clear = 1'b1;
      step();
      clear = 1'b0;
      model.delete();
      check("clr_mid_dump_valid", dump_valid, 0);
      check("clr_mid_dump_count", count, 0);

      // Reset during beat 2 of a 3-beat instance, then a fresh instance.
      cfg_acc_len = LEN_W'(3);
      in_valid = 1'b1; in_data = mk(50, 0, 0, 0); in_index = 40;
      step();
      in_data = mk(60, 0, 0, 0); rst = 1'b0;
      step();
      in_valid = 1'b0; rst = 1'b1;
      model.delete();
      check_reset("rst_accum");
      beats_r[0] = mk(1, 0, 0, 0);
      beats_r[1] = mk(2, 0, 0, 0);
      send_instance(2, 41, 1'b0);
      exp_q = model;
      dump_and_check(0);

      // Reset in the middle of a dump.
      beats_r[0] = mk(-5, 0, 0, 0);
      send_instance(1, 42, 1'b0);
      beats_r[0] = mk(8, 0, 0, 0);
      send_instance(1, 43, 1'b0);
      dump_start = 1'b1;
      step();
      dump_start = 1'b0; dump_ready = 1'b1;
      step();
      rst = 1'b0; dump_ready = 1'b0;
      step();
      rst = 1'b1;
      model.delete();
      check_reset("rst_dump");

      // Randomized instances against the reference list, descending then ascending.
      for (int ph = 0; ph < 2; ph++) begin
         clear_pulse();
         cfg_asce = (ph == 1);
         for (int t = 0; t < 30; t++) begin
            len = int'($urandom_range(0, 4));
            n = (len == 0) ? 1 : len;
            for (int b = 0; b < n; b++) beats_r[b] = mk(rlane(), rlane(), rlane(), rlane());
            cfg_relu_en = 1'($urandom_range(0, 1));
            send_instance(len, 100 + ph * 100 + t, ($urandom_range(0, 3) == 0));
            if ((t % 10) == 9) begin
               exp_q = model;
               dump_and_check(2);
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
